// File: rtl/keynsham_mem_arbiter.sv
// Two-master (instruction/data) arbiter in front of a single shared memory
// slave. One access is in flight at a time; contention is resolved round-robin.
// Every output comes straight from a flop, so the master and slave sides never
// form a combinational path through this block.
module keynsham_mem_arbiter #(
    parameter int timeout_cycles = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction master
    input  logic        i_access,
    input  logic [29:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_ack,
    output logic        i_err,
    // data master
    input  logic        d_access,
    input  logic [29:0] d_addr,
    input  logic [3:0]  d_bytesel,
    input  logic [31:0] d_wr_val,
    input  logic        d_wr_en,
    output logic [31:0] d_data,
    output logic        d_ack,
    output logic        d_err,
    // shared slave
    output logic        m_access,
    output logic [29:0] m_addr,
    output logic [3:0]  m_bytesel,
    output logic [31:0] m_wr_val,
    output logic        m_wr_en,
    input  logic [31:0] m_data,
    input  logic        m_ack
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // last WAIT count before the access is abandoned
    localparam logic [7:0] LAST_CNT = 8'(timeout_cycles - 1);

    logic [1:0] state;
    logic       owner;
    logic       last_grant;
    logic [7:0] cnt;
    logic       grant_d;

    // D wins only if I is idle or I was served last
    always_comb begin
        grant_d = d_access && (!i_access || last_grant == OWN_I);
    end

    // Transaction sequencer: grant, one-cycle issue, wait for ack/timeout, respond
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_grant <= OWN_D;
            cnt        <= 8'd0;
            m_access   <= 1'b0;
            m_addr     <= 30'd0;
            m_bytesel  <= 4'd0;
            m_wr_val   <= 32'd0;
            m_wr_en    <= 1'b0;
            i_data     <= 32'd0;
            i_ack      <= 1'b0;
            i_err      <= 1'b0;
            d_data     <= 32'd0;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_access || d_access) begin
                        owner      <= grant_d;
                        last_grant <= grant_d;
                        m_access   <= 1'b1;
                        state      <= ISSUE;
                        if (grant_d) begin
                            m_addr    <= d_addr;
                            m_bytesel <= d_bytesel;
                            m_wr_val  <= d_wr_val;
                            m_wr_en   <= d_wr_en;
                        end else begin
                            // instruction fetches are always full-word reads
                            m_addr    <= i_addr;
                            m_bytesel <= 4'b1111;
                            m_wr_val  <= 32'd0;
                            m_wr_en   <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    m_access <= 1'b0;
                    cnt      <= 8'd0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (m_ack || cnt == LAST_CNT) begin
                        state <= RESP;
                        if (owner == OWN_D) begin
                            d_ack  <= 1'b1;
                            d_data <= m_ack ? m_data : 32'd0;
                            d_err  <= !m_ack;
                        end else begin
                            i_ack  <= 1'b1;
                            i_data <= m_ack ? m_data : 32'd0;
                            i_err  <= !m_ack;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    // RESP: single-cycle completion, slave bus parked at zero
                    i_ack     <= 1'b0;
                    i_data    <= 32'd0;
                    i_err     <= 1'b0;
                    d_ack     <= 1'b0;
                    d_data    <= 32'd0;
                    d_err     <= 1'b0;
                    m_addr    <= 30'd0;
                    m_bytesel <= 4'd0;
                    m_wr_val  <= 32'd0;
                    m_wr_en   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keynsham_mem_arbiter.sv
// Directed bench for keynsham_mem_arbiter: single fetch, round-robin
// contention, data write, timeout with stray ack, and mid-access reset.
module tb_keynsham_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_access = 1'b0;
    logic [29:0] i_addr = '0;
    logic [31:0] i_data;
    logic        i_ack, i_err;
    logic        d_access = 1'b0;
    logic [29:0] d_addr = '0;
    logic [3:0]  d_bytesel = '0;
    logic [31:0] d_wr_val = '0;
    logic        d_wr_en = 1'b0;
    logic [31:0] d_data;
    logic        d_ack, d_err;
    logic        m_access;
    logic [29:0] m_addr;
    logic [3:0]  m_bytesel;
    logic [31:0] m_wr_val;
    logic        m_wr_en;
    logic [31:0] m_data = '0;
    logic        m_ack = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    keynsham_mem_arbiter #(.timeout_cycles(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_access(i_access), .i_addr(i_addr), .i_data(i_data), .i_ack(i_ack), .i_err(i_err),
        .d_access(d_access), .d_addr(d_addr), .d_bytesel(d_bytesel), .d_wr_val(d_wr_val),
        .d_wr_en(d_wr_en), .d_data(d_data), .d_ack(d_ack), .d_err(d_err),
        .m_access(m_access), .m_addr(m_addr), .m_bytesel(m_bytesel), .m_wr_val(m_wr_val),
        .m_wr_en(m_wr_en), .m_data(m_data), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_issue(input string tag);
        for (int k = 0; k < 8 && !m_access; k++) tick();
        chk(tag, 32'(m_access), 32'd1);
    endtask

    initial begin
        logic exp_d;
        logic [31:0] v;

        // reset state
        tick(); tick();
        chk("rst_m_access", 32'(m_access), 0);
        chk("rst_m_addr", 32'(m_addr), 0);
        chk("rst_m_bytesel", 32'(m_bytesel), 0);
        chk("rst_acks", {30'd0, i_ack, d_ack}, 0);
        chk("rst_data", i_data | d_data, 0);
        rst_n = 1'b1;

        // single instruction fetch, 1-cycle slave
        i_access = 1'b1; i_addr = 30'h10;            // cycle 0
        tick();                                       // cycle 1
        chk("if_m_access", 32'(m_access), 1);
        chk("if_m_addr", 32'(m_addr), 32'h10);
        chk("if_m_bytesel", 32'(m_bytesel), 32'hF);
        chk("if_m_wr_en", 32'(m_wr_en), 0);
        chk("if_m_wr_val", m_wr_val, 0);
        tick();                                       // cycle 2
        chk("if_pulse", 32'(m_access), 0);
        m_ack = 1'b1; m_data = 32'hCAFEF00D;
        tick();                                       // cycle 3
        m_ack = 1'b0; m_data = 32'h0;
        chk("if_ack", 32'(i_ack), 1);
        chk("if_data", i_data, 32'hCAFEF00D);
        chk("if_err", 32'(i_err), 0);
        chk("if_d_ack", 32'(d_ack), 0);
        i_access = 1'b0;
        tick();                                       // cycle 4
        chk("if_ack_clr", 32'(i_ack), 0);
        chk("if_data_clr", i_data, 0);

        // data write, slave acks on the 3rd WAIT cycle
        d_access = 1'b1; d_addr = 30'h20; d_bytesel = 4'h3;
        d_wr_val = 32'h12345678; d_wr_en = 1'b1;
        tick();
        chk("wr_m_access", 32'(m_access), 1);
        chk("wr_m_addr", 32'(m_addr), 32'h20);
        chk("wr_m_bytesel", 32'(m_bytesel), 32'h3);
        chk("wr_m_wr_val", m_wr_val, 32'h12345678);
        chk("wr_m_wr_en", 32'(m_wr_en), 1);
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("wr_wait_access", 32'(m_access), 0);
            chk("wr_wait_addr", 32'(m_addr), 32'h20);
            chk("wr_wait_bsel", 32'(m_bytesel), 32'h3);
            chk("wr_wait_val", m_wr_val, 32'h12345678);
            chk("wr_wait_en", 32'(m_wr_en), 1);
            chk("wr_wait_ack", 32'(d_ack), 0);
            if (w == 2) begin m_ack = 1'b1; m_data = 32'h55AA55AA; end
        end
        tick();
        m_ack = 1'b0; m_data = 32'h0;
        chk("wr_ack", 32'(d_ack), 1);
        chk("wr_err", 32'(d_err), 0);
        chk("wr_data", d_data, 32'h55AA55AA);
        chk("wr_i_ack", 32'(i_ack), 0);
        d_access = 1'b0; d_wr_en = 1'b0;
        tick();
        chk("wr_ack_clr", 32'(d_ack), 0);

        // timeout: slave never acks
        d_access = 1'b1; d_addr = 30'h44; d_bytesel = 4'hF; d_wr_val = 0;
        tick();
        chk("to_m_access", 32'(m_access), 1);
        m_data = 32'hDEADBEEF;
        for (int w = 0; w < TO; w++) begin
            tick();
            chk("to_wait_ack", 32'(d_ack), 0);
        end
        tick();
        chk("to_ack", 32'(d_ack), 1);
        chk("to_err", 32'(d_err), 1);
        chk("to_data", d_data, 0);
        d_access = 1'b0;
        m_ack = 1'b1;                                 // stray late ack
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("to_stray_d_ack", 32'(d_ack), 0);
            chk("to_stray_i_ack", 32'(i_ack), 0);
            chk("to_stray_m_access", 32'(m_access), 0);
        end
        m_ack = 1'b0; m_data = 0;

        // contention from reset release: I, D, I, D
        rst_n = 1'b0;
        i_access = 1'b1; i_addr = 30'h100;
        d_access = 1'b1; d_addr = 30'h200; d_bytesel = 4'hF; d_wr_en = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            exp_d = n[0];
            v = 32'hA0 + 32'(n);
            wait_issue("rr_issue");
            chk("rr_addr", 32'(m_addr), exp_d ? 32'h200 : 32'h100);
            tick();
            m_ack = 1'b1; m_data = v;
            tick();
            m_ack = 1'b0; m_data = 0;
            chk("rr_own_ack", exp_d ? 32'(d_ack) : 32'(i_ack), 1);
            chk("rr_own_data", exp_d ? d_data : i_data, v);
            chk("rr_oth_ack", exp_d ? 32'(i_ack) : 32'(d_ack), 0);
            chk("rr_oth_data", exp_d ? i_data : d_data, 0);
            tick();
            chk("rr_once", {30'd0, i_ack, d_ack}, 0);
        end
        i_access = 1'b0; d_access = 1'b0;
        tick(); tick();

        // reset during WAIT of an instruction fetch
        i_access = 1'b1; i_addr = 30'h300;
        wait_issue("ra_issue");
        tick(); tick();
        chk("ra_pre_addr", 32'(m_addr), 32'h300);
        #2 rst_n = 1'b0;
        #1;
        chk("ra_async_addr", 32'(m_addr), 0);
        chk("ra_async_bsel", 32'(m_bytesel), 0);
        chk("ra_async_ack", {30'd0, i_ack, d_ack}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; i_access = 1'b0;
        m_ack = 1'b1; m_data = 32'h1234;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ra_no_ack", {30'd0, i_ack, d_ack}, 0);
        end
        m_ack = 1'b0; m_data = 0;
        i_access = 1'b1; d_access = 1'b1;
        wait_issue("ra_post_issue");
        chk("ra_post_grant", 32'(m_addr), 32'h300);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
